// File: rtl/jk_scan_bank.sv
// jk_scan_bank: bank of JK flip-flops with a built-in serial scan controller.
// Functional mode applies the JK rule per bit; the scan controller loads a
// pattern MSB-first, applies one capture clock, then unloads the response.
module jk_scan_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    input  logic             scan_start,
    input  logic             scan_in,
    output logic             scan_out,
    output logic             scan_busy,
    output logic             scan_done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] shift_nxt;

    // JK rule result and the one-position scan shift of the current state
    assign jk_nxt    = (j & ~q) | (~k & q);
    assign shift_nxt = {q[WIDTH-2:0], scan_in};
    assign scan_out  = q[WIDTH-1];

    // State, shift counter and flip-flop register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
        end
    end

    // Next state, counter and flip-flop data; scan_start outranks en in IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end else if (en) begin
                    q_nxt = jk_nxt;
                end
            end
            LOAD: begin
                q_nxt = shift_nxt;
                if (cnt == CNT_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            CAPTURE: begin
                q_nxt     = jk_nxt;
                state_nxt = UNLOAD;
                cnt_nxt   = '0;
            end
            UNLOAD: begin
                q_nxt = shift_nxt;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Moore status decode of the registered state
    always_comb begin
        scan_busy = 1'b0;
        scan_done = 1'b0;
        case (state)
            LOAD, CAPTURE, UNLOAD: scan_busy = 1'b1;
            DONE:                  scan_done = 1'b1;
            default:               ;
        endcase
    end

endmodule

// File: tb/tb_jk_scan_bank.sv
// Bench for jk_scan_bank: vector table for the functional JK mode, directed
// scan sequences, and randomized runs against a per-bit behavioural model.
module tb_jk_scan_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] q;
    logic       scan_start;
    logic       scan_in;
    logic       scan_out;
    logic       scan_busy;
    logic       scan_done;

    logic       en2;
    logic [1:0] j2;
    logic [1:0] k2;
    logic [1:0] q2;
    logic       start2;
    logic       sin2;
    logic       sout2;
    logic       busy2;
    logic       done2;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] q_m;

    jk_scan_bank #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .j(j), .k(k), .q(q),
        .scan_start(scan_start), .scan_in(scan_in), .scan_out(scan_out),
        .scan_busy(scan_busy), .scan_done(scan_done)
    );

    jk_scan_bank #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .j(j2), .k(k2), .q(q2),
        .scan_start(start2), .scan_in(sin2), .scan_out(sout2),
        .scan_busy(busy2), .scan_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] exp_q;
    } vec_t;

    // Reference JK behaviour stated as the hold/set/clear/toggle table per bit
    function automatic logic [7:0] jk_ref(input logic [7:0] cur, input logic [7:0] jj, input logic [7:0] kk);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            case ({jj[b], kk[b]})
                2'b00:   r[b] = cur[b];
                2'b10:   r[b] = 1'b1;
                2'b01:   r[b] = 1'b0;
                default: r[b] = ~cur[b];
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full scan on the 8-bit bank; noise drives ignored inputs randomly
    task automatic scan8(input logic [7:0] pat, input logic [7:0] cj, input logic [7:0] ck, input bit noise);
        int         busy_n;
        int         done_n;
        logic [7:0] cap;
        logic [7:0] sh;
        logic [7:0] q_start;
        busy_n  = 0;
        done_n  = 0;
        q_start = q_m;
        scan_start = 1'b1;
        en = noise;
        j  = 8'hFF;
        k  = 8'h00;
        tick();
        busy_n += int'(scan_busy);
        done_n += int'(scan_done);
        chk("start_q_unchanged", 32'(q), 32'(q_start));
        for (int i = 0; i < 8; i++) begin
            scan_in    = pat[7-i];
            scan_start = noise && (i == 3);
            en         = noise ? 1'($urandom) : 1'b0;
            j          = noise ? 8'($urandom) : 8'h00;
            k          = noise ? 8'($urandom) : 8'h00;
            tick();
            busy_n += int'(scan_busy);
            done_n += int'(scan_done);
        end
        scan_start = 1'b0;
        chk("load_q", 32'(q), 32'(pat));
        j  = cj;
        k  = ck;
        en = noise ? 1'($urandom) : 1'b0;
        tick();
        busy_n += int'(scan_busy);
        done_n += int'(scan_done);
        cap = jk_ref(pat, cj, ck);
        chk("capture_q", 32'(q), 32'(cap));
        sh = cap;
        for (int i = 0; i < 8; i++) begin
            chk("unload_bit", 32'(scan_out), 32'(cap[7-i]));
            scan_in = 1'($urandom);
            sh      = {sh[6:0], scan_in};
            en      = noise ? 1'b1 : 1'b0;
            j       = noise ? 8'($urandom) : 8'h00;
            k       = noise ? 8'($urandom) : 8'h00;
            tick();
            busy_n += int'(scan_busy);
            done_n += int'(scan_done);
        end
        chk("done_pulse", 32'(scan_done), 32'd1);
        chk("done_busy_low", 32'(scan_busy), 32'd0);
        en = 1'b0;
        tick();
        busy_n += int'(scan_busy);
        done_n += int'(scan_done);
        chk("busy_cycles", 32'(busy_n), 32'd17);
        chk("done_cycles", 32'(done_n), 32'd1);
        chk("post_scan_q", 32'(q), 32'(sh));
        q_m = sh;
    endtask

    vec_t vecs[8];

    initial begin
        int busy2_n;
        int done_seen;

        vecs[0] = '{en: 1'b1, j: 8'hF0, k: 8'h00, exp_q: 8'hF0};
        vecs[1] = '{en: 1'b1, j: 8'h00, k: 8'h30, exp_q: 8'hC0};
        vecs[2] = '{en: 1'b1, j: 8'hFF, k: 8'hFF, exp_q: 8'h3F};
        vecs[3] = '{en: 1'b0, j: 8'hA5, k: 8'h5A, exp_q: 8'h3F};
        vecs[4] = '{en: 1'b0, j: 8'hFF, k: 8'hFF, exp_q: 8'h3F};
        vecs[5] = '{en: 1'b1, j: 8'h00, k: 8'h00, exp_q: 8'h3F};
        vecs[6] = '{en: 1'b1, j: 8'h0F, k: 8'h0F, exp_q: 8'h30};
        vecs[7] = '{en: 1'b1, j: 8'hC3, k: 8'h30, exp_q: 8'hC3};

        rst_n = 1'b0; en = 1'b0; j = '0; k = '0; scan_start = 1'b0; scan_in = 1'b0;
        en2 = 1'b0; j2 = '0; k2 = '0; start2 = 1'b0; sin2 = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom); j = 8'($urandom); k = 8'($urandom);
            scan_start = 1'($urandom); scan_in = 1'($urandom);
            tick();
        end
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(scan_busy), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_scan_out", 32'(scan_out), 32'd0);
        chk("rst_q2", 32'(q2), 32'h0);
        rst_n = 1'b1; en = 1'b0; scan_start = 1'b0;
        tick();
        chk("idle_hold", 32'(q), 32'h00);

        // functional vector table
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en; j = vecs[i].j; k = vecs[i].k;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
        end
        en = 1'b0;
        q_m = 8'hC3;

        // directed full scan: pattern A5, capture 0F/F0 -> unload 0F
        scan8(8'hA5, 8'h0F, 8'hF0, 1'b0);

        // priority of scan_start over en, mid-LOAD restart and en in UNLOAD
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        q_m = 8'h00;
        scan8(8'h3C, 8'hAA, 8'h55, 1'b1);

        // reset on the third UNLOAD cycle aborts the scan
        scan_start = 1'b1; tick(); scan_start = 1'b0;
        for (int i = 0; i < 8; i++) begin scan_in = 1'($urandom); tick(); end
        j = 8'h11; k = 8'h22; tick();
        tick(); tick();
        chk("abort_busy_before", 32'(scan_busy), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy", 32'(scan_busy), 32'd0);
        chk("abort_scan_out", 32'(scan_out), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            done_seen += int'(scan_done);
            tick();
        end
        done_seen += int'(scan_done);
        chk("abort_no_done", 32'(done_seen), 32'd0);
        q_m = 8'h00;
        scan8(8'h96, 8'hF0, 8'h0F, 1'b0);

        // randomized functional mode interleaved with random scans
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 30; c++) begin
                en = 1'($urandom); j = 8'($urandom); k = 8'($urandom);
                if (en) q_m = jk_ref(q_m, j, k);
                tick();
                chk("rand_func_q", 32'(q), 32'(q_m));
            end
            en = 1'b0;
            scan8(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // two-bit bank: load 11, capture j=00 k=01 -> 10
        busy2_n = 0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        busy2_n += int'(busy2);
        sin2 = 1'b1; tick(); busy2_n += int'(busy2);
        sin2 = 1'b1; tick(); busy2_n += int'(busy2);
        chk("w2_load_q", 32'(q2), 32'h3);
        j2 = 2'b00; k2 = 2'b01; tick(); busy2_n += int'(busy2);
        chk("w2_capture_q", 32'(q2), 32'h2);
        chk("w2_unload0", 32'(sout2), 32'd1);
        sin2 = 1'b0; tick(); busy2_n += int'(busy2);
        chk("w2_unload1", 32'(sout2), 32'd0);
        tick(); busy2_n += int'(busy2);
        chk("w2_done", 32'(done2), 32'd1);
        chk("w2_busy_cycles", 32'(busy2_n), 32'd5);
        tick();
        chk("w2_done_clear", 32'(done2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
